// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the matrix keypad scanner/encoder.
//   - scan_state_t : scan FSM state encoding
//   - key_evt_t    : press/release event layout {code, pressed}; code is
//                    sized for the largest supported keypad and users keep
//                    only the low bits they need
//   - clog2        : ceiling log2 usable in localparam expressions
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    PDEB = 2'd1,
    HELD = 2'd2,
    RDEB = 2'd3
  } scan_state_t;

  localparam int EVT_CODE_MAX_W = 16;

  typedef struct packed {
    logic [EVT_CODE_MAX_W-1:0] code;
    logic                      pressed;
  } key_evt_t;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// keypad_scan_encoder_if
//   Event handshake between the keypad encoder and its consumer.
//   code    : key index r*COLS + c
//   pressed : 1 = press event, 0 = release event
//   valid   : event available, held until accepted
//   ready   : consumer accepts when valid && ready at a clock edge
//   master  : encoder side (drives code/pressed/valid)
//   slave   : consumer side (drives ready)
interface keypad_scan_encoder_if #(
  parameter int CODE_W = 4
);

  logic [CODE_W-1:0] code;
  logic              pressed;
  logic              valid;
  logic              ready;

  modport master (
    output code,
    output pressed,
    output valid,
    input  ready
  );

  modport slave (
    input  code,
    input  pressed,
    input  valid,
    output ready
  );

endinterface

// File: rtl/keypad_scan_encoder_row_sync.sv
// row_sync
//   Two-flop vector synchronizer for the raw keypad row lines.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low; clears both flop stages
//   d     : asynchronous input vector (W bits)
//   q     : synchronized output, two cycles behind d
module row_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Each row bit is treated independently; the scan FSM only samples
  // after the settle window, so bits from different stages never mix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
//   Parametrised matrix-keypad scanner/encoder. Walks a one-hot column
//   drive, samples synchronized rows after a settle window, debounces
//   presses and releases, rejects multi-row ghosting and reports events
//   through a single-entry valid/ready register.
//   Ports:
//     clk       : system clock, rising edge
//     reset     : asynchronous, active-low
//     row       : raw row lines, bit r high = key (r, driven column) closed
//     col       : one-hot column drive
//     multi_key : 1-cycle pulse, more than one row active in sampled column
//     overflow  : 1-cycle pulse, event dropped because register was full
//     evt       : event handshake (code, pressed, valid out; ready in)
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYC     = 3,
  parameter int DEBOUNCE_CYC   = 8,
  parameter int REPORT_RELEASE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ROWS-1:0]       row,
  output logic [COLS-1:0]       col,
  output logic                  multi_key,
  output logic                  overflow,
  keypad_scan_encoder_if.master evt
);

  localparam int CODE_W = clog2(ROWS * COLS);
  localparam int CIW    = clog2(COLS);
  localparam int RIW    = (ROWS > 1) ? clog2(ROWS) : 1;
  localparam int SW     = clog2(SETTLE_CYC + 1);
  localparam int DW     = clog2(DEBOUNCE_CYC + 1);

  scan_state_t       state, state_nxt;
  logic [SW-1:0]     settle_cnt, settle_nxt;
  logic [DW-1:0]     deb_cnt, deb_nxt;
  logic [CIW-1:0]    col_idx, col_nxt, col_adv;
  logic [RIW-1:0]    cand_row, cand_row_nxt, hit_row;
  logic [CODE_W-1:0] cand_code, cand_code_nxt;
  logic [ROWS-1:0]   s_row, cand_mask;
  logic              any_row, many_rows;
  logic              emit, emit_pressed, multi_nxt;
  logic [CODE_W-1:0] code_q;
  logic              pressed_q, valid_q;

  row_sync #(.W(ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (s_row)
  );

  assign col       = COLS'(1) << col_idx;
  assign col_adv   = (col_idx == CIW'(COLS - 1)) ? '0 : col_idx + CIW'(1);
  assign cand_mask = ROWS'(1) << cand_row;

  // Clearing the lowest set bit leaves something only if two or more rows
  // are active, which avoids a full popcount.
  assign any_row   = |s_row;
  assign many_rows = |(s_row & (s_row - ROWS'(1)));

  // Index of the active row; only used when exactly one row is set.
  always_comb begin
    hit_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (s_row[r]) hit_row = RIW'(r);
    end
  end

  // Scan FSM next-state logic. The column only moves in SCAN after a
  // sample, or when a debounce attempt ends; it stays put while a key is
  // being qualified or held so the same switch is watched throughout.
  always_comb begin
    state_nxt     = state;
    settle_nxt    = settle_cnt;
    deb_nxt       = deb_cnt;
    col_nxt       = col_idx;
    cand_row_nxt  = cand_row;
    cand_code_nxt = cand_code;
    emit          = 1'b0;
    emit_pressed  = 1'b0;
    multi_nxt     = 1'b0;

    case (state)
      SCAN: begin
        if (settle_cnt < SW'(SETTLE_CYC)) begin
          settle_nxt = settle_cnt + SW'(1);
        end else begin
          settle_nxt = '0;
          if (!any_row) begin
            col_nxt = col_adv;
          end else if (many_rows) begin
            multi_nxt = 1'b1;
            col_nxt   = col_adv;
          end else begin
            cand_row_nxt  = hit_row;
            cand_code_nxt = CODE_W'(int'(hit_row) * COLS + int'(col_idx));
            deb_nxt       = DW'(1);
            state_nxt     = PDEB;
          end
        end
      end

      PDEB: begin
        if (s_row == cand_mask) begin
          if (deb_cnt >= DW'(DEBOUNCE_CYC - 1)) begin
            emit         = 1'b1;
            emit_pressed = 1'b1;
            state_nxt    = HELD;
          end else begin
            deb_nxt = deb_cnt + DW'(1);
          end
        end else begin
          col_nxt    = col_adv;
          settle_nxt = '0;
          state_nxt  = SCAN;
        end
      end

      HELD: begin
        if (!s_row[cand_row]) begin
          deb_nxt   = DW'(1);
          state_nxt = RDEB;
        end
      end

      RDEB: begin
        if (!s_row[cand_row]) begin
          if (deb_cnt >= DW'(DEBOUNCE_CYC - 1)) begin
            emit       = (REPORT_RELEASE != 0);
            col_nxt    = col_adv;
            settle_nxt = '0;
            state_nxt  = SCAN;
          end else begin
            deb_nxt = deb_cnt + DW'(1);
          end
        end else begin
          state_nxt = HELD;
        end
      end

      default: begin
        state_nxt  = SCAN;
        settle_nxt = '0;
        col_nxt    = '0;
      end
    endcase
  end

  // Scan FSM state, counters, candidate key and multi-key pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      settle_cnt <= '0;
      deb_cnt    <= '0;
      col_idx    <= '0;
      cand_row   <= '0;
      cand_code  <= '0;
      multi_key  <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      deb_cnt    <= deb_nxt;
      col_idx    <= col_nxt;
      cand_row   <= cand_row_nxt;
      cand_code  <= cand_code_nxt;
      multi_key  <= multi_nxt;
    end
  end

  // Single-entry event register. A new event is refused only when the old
  // one is still waiting and not being taken this cycle; an accept and a
  // new emit in the same cycle hand over without a gap in valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q    <= '0;
      pressed_q <= 1'b0;
      valid_q   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (emit) begin
        if (valid_q && !evt.ready) begin
          overflow <= 1'b1;
        end else begin
          code_q    <= cand_code;
          pressed_q <= emit_pressed;
          valid_q   <= 1'b1;
        end
      end else if (valid_q && evt.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign evt.code    = code_q;
  assign evt.pressed = pressed_q;
  assign evt.valid   = valid_q;

endmodule
